// File: rtl/fifo_pkg.sv
// Shared types and default sizes for the dual-clock FIFO controller and its read engine.
package fifo_pkg;

  localparam int ADDRBIT_DEF  = 5;
  localparam int DATABIT_DEF  = 8;
  localparam int BURSTLEN_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    FLUSH = 2'd3
  } rd_state_t;

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry valid/ready skid buffer; the writer must only push when a slot is free
// after this cycle's pop, so there is no in_ready.
module fifo_skid2 import fifo_pkg::*; #(
  parameter int DATABIT = DATABIT_DEF
) (
  input  logic               clkr,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DATABIT-1:0] in_data,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DATABIT-1:0] out_data,
  output logic [1:0]         occupancy
);

  logic [DATABIT-1:0] head;
  logic [DATABIT-1:0] tail;
  logic [1:0]         count;
  logic               pop;

  assign pop       = (count != 2'd0) && out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = head;
  assign occupancy = count;

  // NOTE: the data registers are reset too, so out_data reads 0 after reset.
  always_ff @(posedge clkr or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case ({in_valid, pop})
        2'b10: begin
          if (count == 2'd0) head <= in_data;
          else               tail <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push and pop: occupancy is unchanged, entries shift.
          if (count == 2'd1) begin
            head <= in_data;
          end else begin
            head <= tail;
            tail <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst engine of the dual-clock FIFO (clkr domain): pops words, buffers them
// in a skid and streams them out as bursts. Define FIFO_READER_TIMEOUT_EN for partial-burst flush.
module fifo_burst_reader import fifo_pkg::*; #(
  parameter int ADDRBIT  = ADDRBIT_DEF,
  parameter int DATABIT  = DATABIT_DEF,
  parameter int BURSTLEN = BURSTLEN_DEF,
  parameter int TIMEOUT  = 16
) (
  input  logic               clkr,
  input  logic               rst,
  input  logic               notempty,
  input  logic [ADDRBIT:0]   fifolen,
  output logic               fiford,
  input  logic [DATABIT-1:0] rddata,
  output logic [DATABIT-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy
);

  localparam int CW = ADDRBIT + 1;
  localparam logic [CW-1:0] BURST_W = CW'(BURSTLEN);

  if (BURSTLEN < 1 || BURSTLEN > (1 << ADDRBIT) || TIMEOUT < 1 || TIMEOUT > 256) begin : g_bad_param
    $error("fifo_burst_reader: BURSTLEN or TIMEOUT out of range");
  end

  rd_state_t       state;
  logic [CW-1:0]   issued;
  logic [CW-1:0]   returned;
  logic [CW-1:0]   target;
  logic            inflight;
  logic            xfer;
  logic            reading;
  logic            on_last;
  logic            last_xfer;
  logic [1:0]      occ;
  logic [2:0]      fill;

`ifdef FIFO_READER_TIMEOUT_EN
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
  logic [7:0] timer;
`endif

  fifo_skid2 #(.DATABIT(DATABIT)) u_skid (
    .clkr      (clkr),
    .rst       (rst),
    .in_valid  (inflight),
    .in_data   (rddata),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .occupancy (occ)
  );

  assign xfer      = out_valid & out_ready;
  assign reading   = (state == BURST) || (state == FLUSH);
  assign on_last   = (returned + CW'(1)) == target;
  assign last_xfer = xfer && on_last;
  assign out_last  = out_valid && reading && on_last;

  // A word leaving the skid this cycle frees its slot for the word popped now,
  // which keeps one pop per cycle while the stream is accepting.
  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    fill   = 3'(occ) + 3'(inflight) - 3'(xfer);
    fiford = reading && (issued < target) && notempty && (fill < 3'd2);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clkr or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      issued   <= '0;
      returned <= '0;
      target   <= '0;
      inflight <= 1'b0;
      busy     <= 1'b0;
`ifdef FIFO_READER_TIMEOUT_EN
      timer    <= 8'd0;
`endif
    end else begin
      inflight <= fiford;
      if (fiford) issued   <= issued + CW'(1);
      if (xfer)   returned <= returned + CW'(1);

      case (state)
        IDLE: begin
          busy <= notempty;
          if (notempty) begin
            state <= WAIT;
`ifdef FIFO_READER_TIMEOUT_EN
            timer <= 8'd0;
`endif
          end
        end

        WAIT: begin
          busy <= 1'b1;
          if (fifolen >= BURST_W) begin
            state  <= BURST;
            target <= BURST_W;
`ifdef FIFO_READER_TIMEOUT_EN
          end else if (timer == TIMER_LAST) begin
            state  <= FLUSH;
            target <= fifolen;
          end else if (timer != 8'hFF) begin
            timer <= timer + 8'd1;
`endif
          end
        end

        BURST, FLUSH: begin
          busy <= !last_xfer;
          if (last_xfer) begin
            state    <= IDLE;
            issued   <= '0;
            returned <= '0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: FIFO environment, per-cycle rule checker
// with a scoreboard, directed scenarios and a randomized phase.
module tb_fifo_burst_reader;

  localparam int AB = 5;
  localparam int DB = 8;
  localparam int BL = 4;
  localparam int TO = 16;

  logic          clkr = 1'b0;
  logic          rst = 1'b1;
  logic          notempty = 1'b0;
  logic [AB:0]   fifolen = '0;
  logic          fiford;
  logic [DB-1:0] rddata = '0;
  logic [DB-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          busy;

  always #5 clkr = ~clkr;

  fifo_burst_reader #(.ADDRBIT(AB), .DATABIT(DB), .BURSTLEN(BL), .TIMEOUT(TO)) dut (
    .clkr      (clkr),
    .rst       (rst),
    .notempty  (notempty),
    .fifolen   (fifolen),
    .fiford    (fiford),
    .rddata    (rddata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO environment and scoreboard of words in write order
  logic [DB-1:0] fifo_q[$];
  logic [DB-1:0] exp_q[$];
  int            cyc = 0;
  int            push_cyc = 0;

  task automatic upd_flags();
    fifolen  = (AB+1)'(fifo_q.size());
    notempty = (fifo_q.size() != 0);
  endtask

  task automatic push(input logic [DB-1:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
    push_cyc = cyc + 1;
    upd_flags();
  endtask

  // One clock: the pop seen mid-cycle is applied after the edge, data returned next cycle.
  task automatic tick();
    logic p;
    @(negedge clkr);
    p = fiford;
    @(posedge clkr);
    #1;
    if (p) begin
      check("env_pop_nonempty", fifo_q.size() != 0, 1);
      if (fifo_q.size() != 0) rddata = fifo_q.pop_front();
    end
    upd_flags();
  endtask

  // Event logs filled by the checker
  int            pop_cyc[$];
  int            xc[$];
  logic [DB-1:0] xd[$];
  logic          xl[$];

  task automatic clear_logs();
    pop_cyc.delete();
    xc.delete();
    xd.delete();
    xl.delete();
  endtask

  // Per-cycle rule checker
  int            outst = 0;
  int            bwords = 0;
  int            bpops = 0;
  logic          pv = 1'b0, pr = 1'b0, pl = 1'b0, after_last = 1'b0;
  logic [DB-1:0] pd = '0;
  logic [DB-1:0] expd;

  always @(negedge clkr) begin
    if (rst) begin
      outst = 0; bwords = 0; bpops = 0;
      pv = 1'b0; after_last = 1'b0;
    end else begin
      cyc++;
      if (after_last) begin
        check("idle_busy", busy, 0);
        check("idle_valid", out_valid, 0);
      end
      after_last = 1'b0;
      if (pv && !pr) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, pd);
        check("hold_last", out_last, pl);
      end
      if (!out_valid) check("last_qual", out_last, 0);
      if (fiford) begin
        check("pop_notempty", notempty, 1);
`ifndef FIFO_READER_TIMEOUT_EN
        if (bpops == 0) check("pop_full_burst", fifolen >= BL, 1);
`endif
        bpops++;
        check("pop_per_burst", bpops <= BL, 1);
        pop_cyc.push_back(cyc);
        outst++;
      end
      if (out_valid && out_ready) begin
        check("xfer_avail", exp_q.size() != 0, 1);
        expd = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        check("xfer_data", out_data, expd);
        bwords++;
        outst--;
`ifdef FIFO_READER_TIMEOUT_EN
        if (out_last) check("last_count", bwords, bpops);
        if (bwords == BL) check("last_full", out_last, 1);
`else
        check("xfer_last", out_last, bwords == BL);
`endif
        xc.push_back(cyc);
        xd.push_back(out_data);
        xl.push_back(out_last);
        if (out_last) begin
          check("last_drained", outst, 0);
          bwords = 0;
          bpops = 0;
          after_last = 1'b1;
        end
      end
      check("outstanding", (outst >= 0) && (outst <= 2), 1);
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
    end
  end

  task automatic run_until_xfers(input int n, input int budget, input string tag);
    int k = 0;
    while (xd.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_budget"}, xd.size() >= n, 1);
  endtask

  task automatic check_burst(input string tag, input logic [DB-1:0] base, input int n, input int lastpos);
    check({tag, "_count"}, xd.size(), n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_data"}, xd[i], base + DB'(i));
      check({tag, "_last"}, xl[i], ((i + 1) % lastpos) == 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int total;
    int expect_x;

    // Reset state
    repeat (3) @(negedge clkr);
    check("rst_fiford", fiford, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_data", out_data, 0);
    #2 rst = 1'b0;

    // Full burst with the stream always ready
    clear_logs();
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    run_until_xfers(4, 40, "full");
    tick(); tick();
    check("full_pops", pop_cyc.size(), 4);
    check("full_pop_start", pop_cyc[0] - push_cyc, 2);
    check("full_first_valid", xc[0] - pop_cyc[0], 2);
    for (int i = 1; i < 4; i++) begin
      check("full_pop_consec", pop_cyc[i] - pop_cyc[0], i);
      check("full_xfer_consec", xc[i] - xc[0], i);
    end
    check_burst("full", 8'hA0, 4, 4);
    check("full_busy_after", busy, 0);

    // Backpressure: only two pops while the stream is stalled
    clear_logs();
    out_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
    repeat (14) tick();
    check("bp_pops", pop_cyc.size(), 2);
    check("bp_valid", out_valid, 1);
    check("bp_head", out_data, 8'hB0);
    out_ready = 1'b1;
    run_until_xfers(4, 40, "bp");
    tick(); tick();
    check_burst("bp", 8'hB0, 4, 4);
    check("bp_pops_total", pop_cyc.size(), 4);

`ifdef FIFO_READER_TIMEOUT_EN
    // Partial burst flushed after TIMEOUT cycles in WAIT
    clear_logs();
    tick();
    push(8'hC0); push(8'hC1);
    run_until_xfers(2, 60, "tmo");
    tick(); tick();
    check("tmo_pop_start", pop_cyc[0] - push_cyc, TO + 1);
    check("tmo_pops", pop_cyc.size(), 2);
    check_burst("tmo", 8'hC0, 2, 2);
`else
    // Residual words stay put until a full burst is available
    clear_logs();
    tick();
    push(8'hC0); push(8'hC1);
    repeat (100) tick();
    check("nto_pops", pop_cyc.size(), 0);
    check("nto_busy_wait", busy, 1);
    push(8'hC2); push(8'hC3);
    run_until_xfers(4, 40, "nto");
    tick(); tick();
    check_burst("nto", 8'hC0, 4, 4);
`endif

    // Back-to-back bursts
    clear_logs();
    tick();
    for (int i = 0; i < 8; i++) push(8'hD0 + 8'(i));
    run_until_xfers(8, 80, "b2b");
    tick(); tick();
    check_burst("b2b", 8'hD0, 8, 4);
    check("b2b_gap", (pop_cyc[4] - xc[3]) <= 3, 1);

    // Reset in the middle of a burst
    clear_logs();
    tick();
    for (int i = 0; i < 4; i++) push(8'hE0 + 8'(i));
    run_until_xfers(2, 40, "mrst");
    rst = 1'b1;
    #1;
    check("mrst_fiford", fiford, 0);
    check("mrst_valid", out_valid, 0);
    check("mrst_last", out_last, 0);
    check("mrst_busy", busy, 0);
    check("mrst_data", out_data, 0);
    fifo_q.delete();
    exp_q.delete();
    upd_flags();
    repeat (2) @(negedge clkr);
    #2 rst = 1'b0;
    clear_logs();
    repeat (5) tick();
    check("mrst_no_pop", pop_cyc.size(), 0);
    check("mrst_idle", busy, 0);
    for (int i = 0; i < 4; i++) push(8'hF0 + 8'(i));
    run_until_xfers(4, 40, "mrst_again");
    tick(); tick();
    check_burst("mrst_again", 8'hF0, 4, 4);

    // Randomized traffic with random stalls
    clear_logs();
    total = 0;
    repeat (400) begin
      tick();
      out_ready = ($urandom_range(0, 3) != 0);
      if (fifo_q.size() < 28 && $urandom_range(0, 2) == 0) begin
        push(8'($urandom));
        total++;
      end
    end
    out_ready = 1'b1;
    repeat (80) tick();
`ifdef FIFO_READER_TIMEOUT_EN
    expect_x = total;
`else
    expect_x = (total / BL) * BL;
`endif
    check("rand_delivered", xd.size(), expect_x);
    check("rand_residual", fifo_q.size(), total - expect_x);
    check("rand_idle", busy, (total - expect_x) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
